bcd_down_counter: RTL and testbench
===================================

Name: bcd_down_counter

Overview:
- Multi-digit BCD countdown counter, the decrementing counterpart of the team's BCD increment datapath.
- Loads a BCD start value and decrements by one on each qualified enable tick, borrowing digit to digit.
- Flags terminal count with a one-cycle done pulse.
- Used as a countdown timer or event counter in front of a seven-segment display path.

Parameters:
- DIGITS, 4, number of BCD digits; count width is 4*DIGITS bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  load ld_val and begin counting; valid in any state.
- ld_val  input  4*DIGITS  BCD start value; digit i occupies bits [4i+3:4i].
- en  input  1  count tick; one decrement per cycle in which en=1 while RUN.
- abort  input  1  stop counting, hold the current count, return to IDLE.
- cnt  output  4*DIGITS  current BCD count, registered.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the count reaches zero.

Behaviour:
- Reset (rst_n=0, asynchronous): cnt=0, state=IDLE, busy=0, done=0, internal reload register=0.
- States: IDLE, RUN, DONE. busy=(state==RUN); done=(state==DONE); both are derived from registered state with no input-to-output paths.
- Priority, highest first: start, abort, en.
- start, any state:
  - cnt <= sanitized ld_val next cycle; any digit >9 is clamped to 9.
  - Reload register <= sanitized ld_val.
  - If the sanitized value is nonzero, go to RUN; if it is zero, go to DONE.
  - start during RUN restarts the count; start during DONE overrides the DONE->IDLE exit.
- abort, not coinciding with start: state <= IDLE, cnt held, done not pulsed.
- RUN with en=1 and no start/abort:
  - cnt decrements by one BCD count next cycle.
  - Per digit: 0 -> 9 with borrow to the next digit; otherwise digit-1 and the borrow chain stops.
  - If cnt==1 before the tick (cnt becomes 0), the next state is DONE.
- RUN with en=0: hold.
- DONE: lasts exactly one cycle, then IDLE with cnt=0. Exception: the optional reload feature below.
- IDLE: en is ignored; cnt holds and never wraps below 0.
- Latency: en sampled at edge N gives the updated cnt visible after edge N; done is high during the cycle following the final decrement edge.
- Valid counts are 0 .. 10^DIGITS-1. The 0 -> all-9s wrap never occurs in RUN, because zero always exits to DONE.
- Reset asserted mid-count returns everything to reset values immediately, independent of clk.

Optional Feature:
- Macro: BCD_DOWN_RELOAD_EN.
- Defined:
  - DONE reloads cnt from the reload register and returns to RUN; done still pulses one cycle. This gives a periodic countdown.
  - If the reload register is 0, DONE goes to IDLE.
  - abort remains the only way to stop the counter other than start or reset.
- Not defined: DONE always goes to IDLE holding cnt=0; the reload register is not needed for any output.

Test Plan:
- DIGITS=4; rst_n low with random inputs -> cnt=0000, busy=0, done=0; release -> outputs stay at those values.
- start with ld_val=0x0103, then 4 en ticks -> cnt sequence 0102, 0101, 0100, 0099; busy=1 throughout.
- ld_val=0x0002, 2 en ticks -> cnt 0001 then 0000; done=1 for exactly one cycle, then busy=0; further en leaves cnt=0000.
- start with ld_val=0x1000, 1 tick -> cnt=0999 (borrow across three digits); abort mid-run -> busy=0, cnt holds 0999, no done pulse.
- start with ld_val=0x00A0 -> cnt=0090 (clamped digit); start with ld_val=0x0000 -> done pulses the next cycle with busy=0; start and abort in the same cycle -> start wins.
- With BCD_DOWN_RELOAD_EN defined, ld_val=0x0002 and continuous en -> 0001, 0000 (done pulse), 0002, 0001, ... repeats until abort.

Source files
------------

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: multi-digit BCD countdown counter.
//   Loads a BCD start value (digits >9 clamped to 9) and decrements by one on
//   each en tick while running, borrowing digit to digit. Reaching zero enters
//   DONE for exactly one cycle (done pulse), then IDLE.
//   Optional macro BCD_DOWN_RELOAD_EN: DONE reloads the last loaded value and
//   returns to RUN (periodic countdown); a zero reload value goes to IDLE.
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   start   load ld_val and begin counting (highest priority, any state)
//   ld_val  BCD start value, digit i at [4i+3:4i]
//   en      count tick, honoured only in RUN
//   abort   stop, hold count, return to IDLE
//   cnt     registered BCD count
//   busy    state == RUN
//   done    state == DONE (one-cycle pulse)

// One BCD digit of the decrement datapath: 0 wraps to 9 under a borrow.
module bcd_digit_dec (
  input  logic [3:0] d,
  input  logic       bin,
  output logic [3:0] q
);
  always_comb begin
    q = d;
    if (bin) q = (d == 4'd0) ? 4'd9 : d - 4'd1;
  end
endmodule

module bcd_down_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   ld_val,
  input  logic                  en,
  input  logic                  abort,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  busy,
  output logic                  done
);
  localparam int W = 4*DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;

  logic [W-1:0]      ld_san;
  logic [W-1:0]      cnt_dec;
  logic [DIGITS-1:0] borrow;
  logic              cnt_is_one;

  // Borrow enters digit 0 unconditionally; it ripples only through zero digits.
  assign borrow[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_dig
      assign ld_san[4*i +: 4] = (ld_val[4*i +: 4] > 4'd9) ? 4'd9 : ld_val[4*i +: 4];
      bcd_digit_dec u_dig (
        .d   (cnt[4*i +: 4]),
        .bin (borrow[i]),
        .q   (cnt_dec[4*i +: 4])
      );
      if (i < DIGITS-1) begin : g_brw
        assign borrow[i+1] = borrow[i] & (cnt[4*i +: 4] == 4'd0);
      end
    end
  endgenerate

  assign cnt_is_one = (cnt == {{(W-1){1'b0}}, 1'b1});

`ifdef BCD_DOWN_RELOAD_EN
  logic [W-1:0] reload;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      state  <= IDLE;
`ifdef BCD_DOWN_RELOAD_EN
      reload <= '0;
`endif
    end else if (start) begin
      cnt    <= ld_san;
`ifdef BCD_DOWN_RELOAD_EN
      reload <= ld_san;
`endif
      state  <= (ld_san == '0) ? DONE : RUN;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        RUN: if (en) begin
          cnt <= cnt_dec;
          // Zero always exits to DONE, so RUN never sees the 0 -> all-9s wrap.
          if (cnt_is_one) state <= DONE;
        end
        DONE: begin
`ifdef BCD_DOWN_RELOAD_EN
          if (reload != '0) begin
            cnt   <= reload;
            state <= RUN;
          end else begin
            cnt   <= '0;
            state <= IDLE;
          end
`else
          cnt   <= '0;
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_down_counter.sv
// Bench for bcd_down_counter (DIGITS=4): directed steps with explicit expected
// values, then randomized traffic against a decimal-integer reference model.
module tb_bcd_down_counter;
  localparam int DIGITS = 4;
  localparam int W = 4*DIGITS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] ld_val = '0;
  logic         en = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] cnt;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  // Reference model: count kept as a plain decimal integer.
  int m_cnt = 0;
  int m_reload = 0;
  int m_state = 0;  // 0 idle, 1 run, 2 done

  bcd_down_counter #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ld_val(ld_val),
    .en(en), .abort(abort), .cnt(cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    x = v;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int sanitize(input logic [W-1:0] lv);
    int v, p, d;
    v = 0; p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      d = int'(lv[4*k +: 4]);
      if (d > 9) d = 9;
      v = v + d*p;
      p = p*10;
    end
    return v;
  endfunction

  task automatic model_step();
    int v;
    if (!rst_n) begin
      m_cnt = 0; m_reload = 0; m_state = 0;
    end else if (start) begin
      v = sanitize(ld_val);
      m_cnt = v; m_reload = v;
      m_state = (v == 0) ? 2 : 1;
    end else if (abort) begin
      m_state = 0;
    end else if (m_state == 1) begin
      if (en) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_state = 2;
      end
    end else if (m_state == 2) begin
`ifdef BCD_DOWN_RELOAD_EN
      if (m_reload != 0) begin m_cnt = m_reload; m_state = 1; end
      else begin m_cnt = 0; m_state = 0; end
`else
      m_cnt = 0; m_state = 0;
`endif
    end
  endtask

  task automatic check_model(input string tag);
    checks++;
    assert (cnt === to_bcd(m_cnt) && busy === (m_state == 1) && done === (m_state == 2))
    else begin
      errors++;
      $error("FAIL %s: cnt=%h busy=%b done=%b, expected cnt=%h busy=%b done=%b",
             tag, cnt, busy, done, to_bcd(m_cnt), m_state == 1, m_state == 2);
    end
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] ec,
                            input logic eb, input logic ed);
    checks++;
    assert (cnt === ec && busy === eb && done === ed)
    else begin
      errors++;
      $error("FAIL %s: cnt=%h busy=%b done=%b, expected cnt=%h busy=%b done=%b",
             tag, cnt, busy, done, ec, eb, ed);
    end
  endtask

  // One clock: inputs are already set; model follows the same edge.
  task automatic cyc(input logic s, input logic [W-1:0] lv, input logic e,
                     input logic a, input string tag);
    start = s; ld_val = lv; en = e; abort = a;
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  initial begin
    // Reset held with random inputs.
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(1'($urandom), W'($urandom), 1'($urandom), 1'($urandom), "rst_rand");
      expect_out("rst_hold", 16'h0000, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0, "rst_rel");
    expect_out("rst_rel", 16'h0000, 1'b0, 1'b0);

    // Load 0103 and count into the borrow.
    cyc(1'b1, 16'h0103, 1'b0, 1'b0, "ld103");
    expect_out("ld103", 16'h0103, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, "t1"); expect_out("t1", 16'h0102, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, "t2"); expect_out("t2", 16'h0101, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, "t3"); expect_out("t3", 16'h0100, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, "t4"); expect_out("t4", 16'h0099, 1'b1, 1'b0);

    // Terminal count.
    cyc(1'b1, 16'h0002, 1'b0, 1'b0, "ld2");
    cyc(1'b0, '0, 1'b1, 1'b0, "z1"); expect_out("z1", 16'h0001, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, "z0"); expect_out("z0", 16'h0000, 1'b0, 1'b1);
`ifdef BCD_DOWN_RELOAD_EN
    cyc(1'b0, '0, 1'b1, 1'b0, "rl"); expect_out("rl", 16'h0002, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, "rl1"); expect_out("rl1", 16'h0001, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, "rl0"); expect_out("rl0", 16'h0000, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1, "rlab"); expect_out("rlab", 16'h0000, 1'b0, 1'b0);
`else
    cyc(1'b0, '0, 1'b1, 1'b0, "post"); expect_out("post", 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, "nowrap"); expect_out("nowrap", 16'h0000, 1'b0, 1'b0);
`endif

    // Multi-digit borrow, hold, abort.
    cyc(1'b1, 16'h1000, 1'b0, 1'b0, "ld1000");
    cyc(1'b0, '0, 1'b1, 1'b0, "b3"); expect_out("b3", 16'h0999, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, "hold"); expect_out("hold", 16'h0999, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1, "abort"); expect_out("abort", 16'h0999, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, "idle_en"); expect_out("idle_en", 16'h0999, 1'b0, 1'b0);

    // Clamp, zero load, start beats abort.
    cyc(1'b1, 16'h00A0, 1'b0, 1'b0, "clamp"); expect_out("clamp", 16'h0090, 1'b1, 1'b0);
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, "ld0"); expect_out("ld0", 16'h0000, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, "ld0_x"); expect_out("ld0_x", 16'h0000, 1'b0, 1'b0);
    cyc(1'b1, 16'h0005, 1'b0, 1'b1, "st_ab"); expect_out("st_ab", 16'h0005, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, "t5"); expect_out("t5", 16'h0004, 1'b1, 1'b0);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    m_cnt = 0; m_reload = 0; m_state = 0;
    #1 expect_out("async_rst", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0, "after_rst");

    // Randomized traffic against the model; small loads reach zero often.
    for (int k = 0; k < 600; k++) begin
      logic s, e, a;
      logic [W-1:0] lv;
      s  = ($urandom_range(0, 9) == 0);
      a  = ($urandom_range(0, 24) == 0);
      e  = ($urandom_range(0, 3) != 0);
      lv = ($urandom_range(0, 2) == 0) ? W'($urandom) : {8'h00, 8'($urandom)};
      if ($urandom_range(0, 3) == 0) lv = {12'h000, 4'($urandom_range(0, 3))};
      cyc(s, lv, e, a, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
